adder_csa_pipe: RTL and testbench
=================================

# adder_csa_pipe

Parametrised, pipelined carry-select adder: successor to the 16-bit combinational carry-select adder. Adds two WIDTH-bit operands plus carry-in, one BLOCK-bit carry-select slice per pipeline stage, with valid/ready handshakes on both sides and full backpressure. Sits in the arithmetic datapath wherever a wide add must close timing at full clock rate with one result per cycle.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of BLOCK, at least BLOCK.
- BLOCK, 8: bits per carry-select slice; number of pipeline stages NSTG = WIDTH/BLOCK.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry-out, i.e. bit WIDTH of a + b + cin.
- ovf  out  1  signed overflow; present only with ADDER_CSA_PIPE_OVF_EN.

## Operation
- Stage k (0..NSTG-1) computes slice bits [k*BLOCK +: BLOCK]: two ripple sums of the slice operands, one with carry 0 and one with carry 1, selected by the carry registered from stage k-1 (stage 0 uses cin).
- Operand bits not yet consumed travel down the pipeline with the beat. Completed sum bits accumulate in the beat's register. Consumed operand bits are dropped.
- Each stage holds one valid bit. Advance enable: adv = out_ready | ~out_valid; the whole pipeline shifts when adv=1 and holds otherwise (global stall; bubbles are not collapsed).
- in_ready = adv. A beat is accepted when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- A result is delivered when out_valid & out_ready. sum and cout stay stable while out_valid=1 and out_ready=0.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the final slice's selected carry.

## Timing
- Latency: an input accepted at edge t appears with out_valid=1 after edge t+NSTG-1 (NSTG-1 cycles after the accepting edge). With NSTG=1 the result is registered at the accepting edge.
- Throughput: one beat per cycle while out_ready=1.
- Reset (asserted asynchronously, released at any time): all valid bits 0; sum, cout and ovf are 0; in_ready=1 after reset, because out_valid=0. In-flight beats are discarded without being output.
- Simultaneous accept and deliver in the same cycle is legal. The pipeline shifts and both transfers complete.
- in_ready depends combinationally on out_ready and out_valid. There is no path from in_valid to in_ready.

## Configuration
- ADDER_CSA_PIPE_OVF_EN defined: ovf port exists. It is registered alongside the final slice as carry-into-MSB XOR cout, with the same validity and stall behaviour as sum. Its reset value is 0.
- Not defined: no ovf port and no extra register. All other behaviour is identical.

## Structure
- Package adder_csa_pkg: default WIDTH/BLOCK constants and a function computing NSTG. The package also holds the elaboration check that WIDTH % BLOCK == 0.
- Sub-module csa_block (BLOCK-bit carry-select slice: dual ripple adders plus mux). It is purely combinational and is instantiated once per stage. adder_csa_pipe owns all registers and handshake logic.

## Test plan
(Default WIDTH=32, BLOCK=8, so latency is 4 edges.)
- Reset mid-stream: stream 3 beats, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0 immediately. The 3 beats are never delivered, and in_ready=1.
- Single beat a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> after 4 edges out_valid=1, sum=0x0000_0000, cout=1. Carry ripples through all slices.
- Carry-in: a=0, b=0, cin=1 -> sum=0x0000_0001, cout=0; a=0x7FFF_FFFF, b=0, cin=1 -> sum=0x8000_0000, cout=0, ovf=1 (macro on).
- Back-to-back stream of 100 random beats with out_ready=1 -> results arrive in order, one per cycle, each equal to a+b+cin, and in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> sum/cout stay stable, in_ready=0, and no beat is lost or duplicated once out_ready returns to 1.
- Parameter sweep (WIDTH,BLOCK) = (16,4), (16,16), (64,8) with random operands -> results match the reference add, and latency is NSTG-1 edges after acceptance.

Source files
------------

// File: rtl/adder_csa_pkg.sv
// Shared configuration for the pipelined carry-select adder.
//
// Contents:
//   WIDTH_DEF / BLOCK_DEF : default operand width and slice width
//   nstg()                : number of pipeline stages (one per slice)
//   cfg_ok()              : legality check used at elaboration by adder_csa_pipe
//                           (WIDTH must be a non-zero multiple of BLOCK)
package adder_csa_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int BLOCK_DEF = 8;

    function automatic int nstg(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit cfg_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/adder_csa_pipe_csa_block.sv
// csa_block: one BLOCK-bit carry-select slice, purely combinational.
//
// Two sums of the slice operands are formed, one assuming carry-in 0 and one
// assuming carry-in 1; the real carry-in only drives the final mux, so it
// never sits on the adder's critical path.
//
// Ports:
//   a, b     in  BLOCK  slice operands
//   sel_cin  in  1      carry into the slice (selects between the two sums)
//   sum      out BLOCK  selected slice sum
//   cout     out 1      selected slice carry-out
module csa_block
    import adder_csa_pkg::*;
#(
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             sel_cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0] sum_c0;
    logic [BLOCK:0] sum_c1;

    always_comb begin
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
        {cout, sum} = sel_cin ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/adder_csa_pipe.sv
// adder_csa_pipe: pipelined carry-select adder, one BLOCK-bit slice per stage.
//
// Stage k adds slice bits [k*BLOCK +: BLOCK] using the carry registered by
// stage k-1 (stage 0 uses cin). Unconsumed operand bits travel with the beat,
// finished sum bits accumulate in the beat's sum register. The whole pipeline
// advances together (global stall) whenever the output is empty or accepted.
// Latency: NSTG-1 cycles after the accepting edge; one beat per cycle.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   operand beat present       in_ready  beat accepted this cycle
//   a, b, cin  operands and carry-in
//   out_valid  result present             out_ready consumer takes the result
//   sum, cout  (a + b + cin) mod 2^WIDTH and its carry-out
//   ovf        signed overflow, only when ADDER_CSA_PIPE_OVF_EN is defined
module adder_csa_pipe
    import adder_csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_CSA_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSTG = nstg(WIDTH, BLOCK);

    if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
        $error("adder_csa_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    // stg_*[k] is what enters stage k; index NSTG is the last stage's output.
    logic             stg_valid [0:NSTG];
    logic [WIDTH-1:0] stg_sum   [0:NSTG];
    logic             stg_carry [0:NSTG];
    logic [WIDTH-1:0] stg_a     [0:NSTG-1];
    logic [WIDTH-1:0] stg_b     [0:NSTG-1];

    logic adv;

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    assign stg_valid[0] = in_valid;
    assign stg_sum[0]   = '0;
    assign stg_carry[0] = cin;
    assign stg_a[0]     = a;
    assign stg_b[0]     = b;

    assign out_valid = stg_valid[NSTG];
    assign sum       = stg_sum[NSTG];
    assign cout      = stg_carry[NSTG];

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
        logic [BLOCK-1:0] slice_a;
        logic [BLOCK-1:0] slice_b;
        logic [BLOCK-1:0] slice_sum;
        logic             slice_cout;
        logic             valid_d, valid_q;
        logic [WIDTH-1:0] sum_d, sum_q;
        logic             carry_d, carry_q;

        assign slice_a = BLOCK'(stg_a[gi] >> (gi * BLOCK));
        assign slice_b = BLOCK'(stg_b[gi] >> (gi * BLOCK));

        csa_block #(.BLOCK(BLOCK)) u_slice (
            .a       (slice_a),
            .b       (slice_b),
            .sel_cin (stg_carry[gi]),
            .sum     (slice_sum),
            .cout    (slice_cout)
        );

        always_comb begin
            valid_d = stg_valid[gi];
            // Lower slices are already final; OR this slice into its position.
            sum_d   = stg_sum[gi] | (WIDTH'(slice_sum) << (gi * BLOCK));
            carry_d = slice_cout;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (adv) begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign stg_valid[gi+1] = valid_q;
        assign stg_sum[gi+1]   = sum_q;
        assign stg_carry[gi+1] = carry_q;

        // Operand bits still to be added move on; consumed bits are zeroed so
        // their flops reduce to constants.
        if (gi < NSTG - 1) begin : g_ops
            localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((gi + 1) * BLOCK);
            logic [WIDTH-1:0] a_d, a_q;
            logic [WIDTH-1:0] b_d, b_q;

            always_comb begin
                a_d = stg_a[gi] & KEEP;
                b_d = stg_b[gi] & KEEP;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign stg_a[gi+1] = a_q;
            assign stg_b[gi+1] = b_q;
        end

`ifdef ADDER_CSA_PIPE_OVF_EN
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        if (gi == NSTG - 1) begin : g_ovf
            logic ovf_d, ovf_q;

            always_comb begin
                ovf_d = slice_cout ^ (slice_a[BLOCK-1] ^ slice_b[BLOCK-1] ^ slice_sum[BLOCK-1]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf = ovf_q;
        end
`endif
    end

endmodule

// File: tb/tb_adder_csa_pipe.sv
// Self-checking bench for adder_csa_pipe: reset, directed carry cases,
// streaming, backpressure and a (WIDTH,BLOCK) sweep on extra instances.
module tb_adder_csa_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance, WIDTH=32 BLOCK=8
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
`ifdef ADDER_CSA_PIPE_OVF_EN
    logic        ovf;
`endif

    adder_csa_pipe #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef ADDER_CSA_PIPE_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    // sweep instances share stimulus
    logic        sw_in_valid, sw_cin, sw_out_ready;
    logic [63:0] sw_a, sw_b;
    logic        s0_in_ready, s0_out_valid, s0_cout;
    logic [15:0] s0_sum;
    logic        s1_in_ready, s1_out_valid, s1_cout;
    logic [15:0] s1_sum;
    logic        s2_in_ready, s2_out_valid, s2_cout;
    logic [63:0] s2_sum;
`ifdef ADDER_CSA_PIPE_OVF_EN
    logic        s0_ovf, s1_ovf, s2_ovf;
`endif

    adder_csa_pipe #(.WIDTH(16), .BLOCK(4)) dut_16_4 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s0_in_ready),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin),
        .out_valid(s0_out_valid), .out_ready(sw_out_ready), .sum(s0_sum),
`ifdef ADDER_CSA_PIPE_OVF_EN
        .ovf(s0_ovf),
`endif
        .cout(s0_cout)
    );

    adder_csa_pipe #(.WIDTH(16), .BLOCK(16)) dut_16_16 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s1_in_ready),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin),
        .out_valid(s1_out_valid), .out_ready(sw_out_ready), .sum(s1_sum),
`ifdef ADDER_CSA_PIPE_OVF_EN
        .ovf(s1_ovf),
`endif
        .cout(s1_cout)
    );

    adder_csa_pipe #(.WIDTH(64), .BLOCK(8)) dut_64_8 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s2_in_ready),
        .a(sw_a), .b(sw_b), .cin(sw_cin),
        .out_valid(s2_out_valid), .out_ready(sw_out_ready), .sum(s2_sum),
`ifdef ADDER_CSA_PIPE_OVF_EN
        .ovf(s2_ovf),
`endif
        .cout(s2_cout)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        bit quiet_ok;
        // held in reset from time 0
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'h0101_0101 * (i + 1);
            b = 32'h1000_0000;
            cin = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        // first beat is at the output now
        total++; if (out_valid !== 1'b1 || sum !== 32'h1101_0101) begin bad++; $display("FAIL midstream_first: got v=%b sum=%h expected v=1 sum=11010101", out_valid, sum); end
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
        total++; if (sum !== 32'h0 || cout !== 1'b0) begin bad++; $display("FAIL async_rst_data: got sum=%h cout=%b expected 0/0", sum, cout); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        quiet_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet_ok = 1'b0;
        end
        total++; if (!quiet_ok) begin bad++; $display("FAIL flushed_beats: discarded beats reappeared or in_ready dropped"); end
        $display("test_reset done: total=%0d", total);
    endtask

    task automatic run_one(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic vc, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        total++; if (lat != 4) begin bad++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
        total++; if (sum !== es) begin bad++; $display("FAIL %s_sum: got %h expected %h", name, sum, es); end
        total++; if (cout !== ec) begin bad++; $display("FAIL %s_cout: got %b expected %b", name, cout, ec); end
`ifdef ADDER_CSA_PIPE_OVF_EN
        total++; if (ovf !== eo) begin bad++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, eo); end
`endif
        $display("beat %s: a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", name, va, vb, vc, sum, cout, lat);
        @(negedge clk);
    endtask

    task automatic test_single();
        run_one("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("slice_edge", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_one("mixed",      32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
    endtask

    task automatic test_carry_in();
        run_one("cin_only",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        run_one("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        run_one("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_one("all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [32:0] expq[$];
        logic [32:0] e;
        logic [31:0] va, vb;
        logic        vc;
        int got, first, last;
        bit ready_ok;
        got = 0; first = -1; last = -1; ready_ok = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 115; cyc++) begin
            if (out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_extra: got unexpected result %h expected none", sum);
                end else begin
                    e = expq.pop_front();
                    total++;
                    if ({cout, sum} !== e) begin bad++; $display("FAIL b2b_result%0d: got %h expected %h", got, {cout, sum}, e); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 100) begin
                va = $urandom; vb = $urandom; vc = 1'($urandom_range(0, 1));
                a = va; b = vb; cin = vc; in_valid = 1'b1;
                if (in_ready !== 1'b1) ready_ok = 1'b0;
                expq.push_back({1'b0, va} + {1'b0, vb} + {32'b0, vc});
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (got != 100) begin bad++; $display("FAIL b2b_count: got %0d expected 100", got); end
        total++; if (last - first != 99) begin bad++; $display("FAIL b2b_contiguous: got span %0d expected 99", last - first); end
        total++; if (!ready_ok) begin bad++; $display("FAIL b2b_in_ready: got 0 during stream expected 1"); end
        $display("test_back_to_back: %0d results, first at cycle %0d", got, first);
    endtask

    task automatic test_backpressure();
        logic [32:0] expq[$];
        logic [32:0] e, held;
        logic [31:0] va, vb;
        logic        vc;
        int got, idx, stalls;
        bit stable_ok, ready_low_ok;
        got = 0; idx = 0; stalls = 0; stable_ok = 1'b1; ready_low_ok = 1'b1; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 8 && cyc < 13);
            #1;
            if (out_valid === 1'b1) begin
                if (!out_ready) begin
                    if (stalls == 0) held = {cout, sum};
                    else if ({cout, sum} !== held) stable_ok = 1'b0;
                    if (in_ready !== 1'b0) ready_low_ok = 1'b0;
                    stalls++;
                end else if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bp_duplicate: got extra result %h expected none", {cout, sum});
                end else begin
                    e = expq.pop_front();
                    total++;
                    if ({cout, sum} !== e) begin bad++; $display("FAIL bp_result%0d: got %h expected %h", got, {cout, sum}, e); end
                    got++;
                end
            end
            if (idx < 12) begin
                va = 32'hF000_0000 + 32'h0111_1111 * idx;
                vb = 32'h1234_5678 ^ idx;
                vc = idx[0];
                a = va; b = vb; cin = vc; in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    expq.push_back({1'b0, va} + {1'b0, vb} + {32'b0, vc});
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        total++; if (stalls != 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d expected 5", stalls); end
        total++; if (!stable_ok) begin bad++; $display("FAIL bp_stable: output changed while stalled, held %h", held); end
        total++; if (!ready_low_ok) begin bad++; $display("FAIL bp_in_ready: got 1 while stalled expected 0"); end
        total++; if (got != 12 || expq.size() != 0) begin bad++; $display("FAIL bp_count: got %0d delivered, %0d pending expected 12 and 0", got, expq.size()); end
        $display("test_backpressure: delivered %0d beats, %0d stall cycles", got, stalls);
    endtask

    task automatic test_sweep();
        logic [63:0] va[6];
        logic [63:0] vb[6];
        logic        vc[6];
        logic [16:0] e16;
        logic [64:0] e64;
        int lat0, lat1, lat2;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
        va[1] = 64'h0;                   vb[1] = 64'h0; vc[1] = 1'b1;
        va[2] = 64'h0123_4567_89AB_CDEF; vb[2] = 64'hFEDC_BA98_7654_3210; vc[2] = 1'b1;
        for (int i = 3; i < 6; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
            vc[i] = 1'($urandom_range(0, 1));
        end
        sw_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lat0 = 0; lat1 = 0; lat2 = 0;
            e16 = {1'b0, va[i][15:0]} + {1'b0, vb[i][15:0]} + {16'b0, vc[i]};
            e64 = {1'b0, va[i]} + {1'b0, vb[i]} + {64'b0, vc[i]};
            sw_a = va[i]; sw_b = vb[i]; sw_cin = vc[i]; sw_in_valid = 1'b1;
            @(negedge clk);
            sw_in_valid = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (s0_out_valid === 1'b1 && lat0 == 0) begin
                    lat0 = k; total++;
                    if ({s0_cout, s0_sum} !== e16) begin bad++; $display("FAIL sweep16_4_v%0d: got %h expected %h", i, {s0_cout, s0_sum}, e16); end
                end
                if (s1_out_valid === 1'b1 && lat1 == 0) begin
                    lat1 = k; total++;
                    if ({s1_cout, s1_sum} !== e16) begin bad++; $display("FAIL sweep16_16_v%0d: got %h expected %h", i, {s1_cout, s1_sum}, e16); end
                end
                if (s2_out_valid === 1'b1 && lat2 == 0) begin
                    lat2 = k; total++;
                    if ({s2_cout, s2_sum} !== e64) begin bad++; $display("FAIL sweep64_8_v%0d: got %h expected %h", i, {s2_cout, s2_sum}, e64); end
                end
                @(negedge clk);
            end
            total++; if (lat0 != 4) begin bad++; $display("FAIL sweep16_4_lat%0d: got %0d expected 4", i, lat0); end
            total++; if (lat1 != 1) begin bad++; $display("FAIL sweep16_16_lat%0d: got %0d expected 1", i, lat1); end
            total++; if (lat2 != 8) begin bad++; $display("FAIL sweep64_8_lat%0d: got %0d expected 8", i, lat2); end
            $display("sweep v%0d: a=%h b=%h cin=%b lat=%0d/%0d/%0d", i, va[i], vb[i], vc[i], lat0, lat1, lat2);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        sw_in_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_carry_in();
        test_back_to_back();
        test_backpressure();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
